// File: rtl/rpn_stack.sv
// rpn_stack: parametrised LIFO operand stack. The top two elements live in
// registers; deeper elements live in a single-port RAM with registered read.
module rpn_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top0,
  output logic [WIDTH-1:0] top1,
  output logic [CNT_W-1:0] elems_cnt,
  output logic             err,
  output logic             rej
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_THREE = CNT_W'(3);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [WIDTH-1:0] DATA_ZERO = WIDTH'(0);

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_PUSH      = 3'd1;
  localparam logic [2:0] OP_POP       = 3'd2;
  localparam logic [2:0] OP_POP2_PUSH = 3'd3;
  localparam logic [2:0] OP_REPLACE   = 3'd4;
  localparam logic [2:0] OP_SWAP      = 3'd5;
  localparam logic [2:0] OP_DUP       = 3'd6;
  localparam logic [2:0] OP_CLEAR     = 3'd7;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;

  state_e           state_r, state_nxt_s;
  logic [WIDTH-1:0] top0_r, top1_r, top0_nxt_s, top1_nxt_s, rd_data_r;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             err_r, err_nxt_s, rej_r, rej_nxt_s;
  logic             accept_s, legal_s, ram_we_s, ram_re_s;
  logic [AW-1:0]    ram_addr_s;
  logic [WIDTH-1:0] mem [DEPTH];

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next state: a POP-type op with data left in RAM spends one cycle in FILL
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (ram_re_s) state_nxt_s = FILL; else state_nxt_s = IDLE;
      FILL:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    op_ready = 1'b0;
    case (state_r)
      IDLE:    op_ready = 1'b1;
      FILL:    op_ready = 1'b0;
      default: op_ready = 1'b0;
    endcase
  end

  assign accept_s = op_valid && op_ready;

  // Minimum/maximum count each opcode needs
  always_comb begin
    legal_s = 1'b0;
    case (op)
      OP_NOP, OP_CLEAR:      legal_s = 1'b1;
      OP_PUSH:               legal_s = (cnt_r < CNT_FULL);
      OP_POP, OP_REPLACE:    legal_s = (cnt_r >= CNT_ONE);
      OP_POP2_PUSH, OP_SWAP: legal_s = (cnt_r >= CNT_TWO);
      OP_DUP:                legal_s = (cnt_r >= CNT_ONE) && (cnt_r < CNT_FULL);
      default:               legal_s = 1'b0;
    endcase
  end

  // Datapath next values and RAM requests
  always_comb begin
    top0_nxt_s = top0_r;
    top1_nxt_s = top1_r;
    cnt_nxt_s  = cnt_r;
    err_nxt_s  = err_r;
    rej_nxt_s  = 1'b0;
    ram_we_s   = 1'b0;
    ram_re_s   = 1'b0;
    ram_addr_s = AW'(cnt_r - CNT_TWO);
    if (state_r == FILL) begin
      top1_nxt_s = rd_data_r;
    end else if (accept_s && !legal_s) begin
      err_nxt_s = 1'b1;
      rej_nxt_s = 1'b1;
    end else if (accept_s) begin
      case (op)
        OP_PUSH, OP_DUP: begin
          ram_we_s   = (cnt_r >= CNT_TWO);
          top1_nxt_s = top0_r;
          top0_nxt_s = (op == OP_DUP) ? top0_r : wdata;
          cnt_nxt_s  = cnt_r + CNT_ONE;
        end
        OP_POP, OP_POP2_PUSH: begin
          ram_re_s   = (cnt_r >= CNT_THREE);
          ram_addr_s = AW'(cnt_r - CNT_THREE);
          top0_nxt_s = (op == OP_POP) ? top1_r : wdata;
          top1_nxt_s = DATA_ZERO;  // replaced by the FILL when RAM holds more
          cnt_nxt_s  = cnt_r - CNT_ONE;
        end
        OP_REPLACE: top0_nxt_s = wdata;
        OP_SWAP: begin
          top0_nxt_s = top1_r;
          top1_nxt_s = top0_r;
        end
        OP_CLEAR: begin
          top0_nxt_s = DATA_ZERO;
          top1_nxt_s = DATA_ZERO;
          cnt_nxt_s  = CNT_ZERO;
          err_nxt_s  = 1'b0;
        end
        default: begin
          top0_nxt_s = top0_r;
        end
      endcase
    end else begin
      rej_nxt_s = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      top0_r <= DATA_ZERO;
      top1_r <= DATA_ZERO;
      cnt_r  <= CNT_ZERO;
      err_r  <= 1'b0;
      rej_r  <= 1'b0;
    end else begin
      top0_r <= top0_nxt_s;
      top1_r <= top1_nxt_s;
      cnt_r  <= cnt_nxt_s;
      err_r  <= err_nxt_s;
      rej_r  <= rej_nxt_s;
    end
  end

  // Single-port RAM for elements below top1
  always_ff @(posedge clk) begin
    if (rst_n && ram_we_s)      mem[ram_addr_s] <= top1_r;
    else if (rst_n && ram_re_s) rd_data_r <= mem[ram_addr_s];
    else                        rd_data_r <= rd_data_r;
  end

  assign top0      = top0_r;
  assign top1      = top1_r;
  assign elems_cnt = cnt_r;
  assign err       = err_r;
  assign rej       = rej_r;
endmodule

// File: tb/tb_rpn_stack.sv
// tb_rpn_stack: drives a DEPTH=16 and a DEPTH=4 instance through a shared
// stimulus bus; a queue-based stack model provides every expected value.
module tb_rpn_stack;
  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, POP2 = 3'd3;
  localparam logic [2:0] REPL = 3'd4, SWAP = 3'd5, DUP = 3'd6, CLEAR = 3'd7;

  logic        clk = 1'b0, rst_n = 1'b0, op_valid = 1'b0, sel = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] wdata = 32'd0;

  logic        b_ready, b_err, b_rej, s_ready, s_err, s_rej;
  logic [31:0] b_top0, b_top1, s_top0, s_top1;
  logic [4:0]  b_cnt;
  logic [2:0]  s_cnt;
  logic        ready, err, rej;
  logic [31:0] top0, top1, cnt;

  always #5 clk = ~clk;

  rpn_stack #(.WIDTH(32), .DEPTH(16), .CNT_W(5)) dut_big (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid && !sel), .op_ready(b_ready),
    .op(op), .wdata(wdata), .top0(b_top0), .top1(b_top1), .elems_cnt(b_cnt),
    .err(b_err), .rej(b_rej));

  rpn_stack #(.WIDTH(32), .DEPTH(4), .CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid && sel), .op_ready(s_ready),
    .op(op), .wdata(wdata), .top0(s_top0), .top1(s_top1), .elems_cnt(s_cnt),
    .err(s_err), .rej(s_rej));

  always_comb begin
    ready = sel ? s_ready : b_ready;
    err   = sel ? s_err   : b_err;
    rej   = sel ? s_rej   : b_rej;
    top0  = sel ? s_top0  : b_top0;
    top1  = sel ? s_top1  : b_top1;
    cnt   = sel ? 32'(s_cnt) : 32'(b_cnt);
  end

  // Reference model of the selected instance
  logic [31:0] stk[$];
  bit m_err, exp_rej, exp_fill, pending_fill;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [2:0] o; logic [31:0] d; logic [31:0] t0; logic [31:0] t1;
    int cnt; bit rej; bit err; bit rdy;
  } vec_t;
  vec_t tab[$];
  logic [2:0] r_op;

  function automatic logic [31:0] m_t0();
    return (stk.size() >= 1) ? stk[stk.size()-1] : 32'd0;
  endfunction
  function automatic logic [31:0] m_t1();
    return (stk.size() >= 2) ? stk[stk.size()-2] : 32'd0;
  endfunction

  function automatic void apply(input logic [2:0] o, input logic [31:0] d);
    int n = stk.size();
    int depth = sel ? 4 : 16;
    bit ok = 1'b0;
    logic [31:0] a;
    exp_fill = 1'b0;
    case (o)
      PUSH:  if (n < depth) begin ok = 1'b1; stk.push_back(d); end
      DUP:   if (n >= 1 && n < depth) begin ok = 1'b1; stk.push_back(stk[n-1]); end
      POP:   if (n >= 1) begin ok = 1'b1; a = stk.pop_back(); exp_fill = (n >= 3); end
      POP2:  if (n >= 2) begin
               ok = 1'b1; a = stk.pop_back(); a = stk.pop_back();
               stk.push_back(d); exp_fill = (n >= 3);
             end
      REPL:  if (n >= 1) begin ok = 1'b1; stk[n-1] = d; end
      SWAP:  if (n >= 2) begin ok = 1'b1; a = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = a; end
      CLEAR: begin ok = 1'b1; stk.delete(); m_err = 1'b0; end
      default: ok = 1'b1;
    endcase
    exp_rej = !ok;
    if (!ok) m_err = 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Let a pending FILL finish: exactly one cycle, then top1 must hold the RAM value
  task automatic settle();
    if (pending_fill) begin
      @(posedge clk); #1;
      pending_fill = 1'b0;
      chk("fill_ready", 32'(ready), 32'd1);
      chk("fill_top1", top1, m_t1());
    end
  endtask

  // op_valid rises before settle so a request is held through any FILL cycle
  task automatic issue(input logic [2:0] o, input logic [31:0] d);
    op_valid = 1'b1; op = o; wdata = d;
    settle();
    @(posedge clk); #1;
    op_valid = 1'b0;
    apply(o, d);
    chk("rej", 32'(rej), 32'(exp_rej));
    chk("cnt", cnt, 32'(stk.size()));
    chk("top0", top0, m_t0());
    chk("err", 32'(err), 32'(m_err));
    chk("ready", 32'(ready), 32'(!exp_fill));
    if (!exp_fill) chk("top1", top1, m_t1());
    pending_fill = exp_fill;
  endtask

  task automatic do_reset();
    op_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stk.delete(); m_err = 1'b0; pending_fill = 1'b0;
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_top0", top0, 32'd0);
    chk("rst_top1", top1, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rej", 32'(rej), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
  endtask

  function automatic void add(input logic [2:0] o, input logic [31:0] d, input logic [31:0] t0,
                              input logic [31:0] t1, input int c, input bit rj, input bit er, input bit rd);
    vec_t v;
    v.o = o; v.d = d; v.t0 = t0; v.t1 = t1; v.cnt = c; v.rej = rj; v.err = er; v.rdy = rd;
    tab.push_back(v);
  endfunction

  initial begin
    add(PUSH, 32'h11, 32'h11, 32'h0,  1, 0, 0, 1);
    add(PUSH, 32'h22, 32'h22, 32'h11, 2, 0, 0, 1);
    add(PUSH, 32'h33, 32'h33, 32'h22, 3, 0, 0, 1);
    add(POP,  32'h0,  32'h22, 32'h0,  2, 0, 0, 0);
    add(POP,  32'h0,  32'h11, 32'h0,  1, 0, 0, 1);
    add(POP,  32'h0,  32'h0,  32'h0,  0, 0, 0, 1);
    add(POP,  32'h0,  32'h0,  32'h0,  0, 1, 1, 1);
    add(PUSH, 32'h44, 32'h44, 32'h0,  1, 0, 1, 1);
    add(SWAP, 32'h0,  32'h44, 32'h0,  1, 1, 1, 1);
    add(CLEAR,32'h0,  32'h0,  32'h0,  0, 0, 0, 1);
    add(REPL, 32'h99, 32'h0,  32'h0,  0, 1, 1, 1);
    add(CLEAR,32'h0,  32'h0,  32'h0,  0, 0, 0, 1);
    add(PUSH, 32'h5,  32'h5,  32'h0,  1, 0, 0, 1);
    add(PUSH, 32'h7,  32'h7,  32'h5,  2, 0, 0, 1);
    add(PUSH, 32'h9,  32'h9,  32'h7,  3, 0, 0, 1);
    add(POP2, 32'h10, 32'h10, 32'h0,  2, 0, 0, 0);
    add(DUP,  32'h0,  32'h10, 32'h10, 3, 0, 0, 1);
    add(REPL, 32'h77, 32'h77, 32'h10, 3, 0, 0, 1);
    add(SWAP, 32'h0,  32'h10, 32'h77, 3, 0, 0, 1);
    add(POP,  32'h0,  32'h77, 32'h0,  2, 0, 0, 0);
    add(POP,  32'h0,  32'h5,  32'h0,  1, 0, 0, 1);
    add(NOP,  32'h0,  32'h5,  32'h0,  1, 0, 0, 1);
    add(POP,  32'h0,  32'h0,  32'h0,  0, 0, 0, 1);

    sel = 1'b0;
    do_reset();
    for (int i = 0; i < tab.size(); i++) begin
      issue(tab[i].o, tab[i].d);
      chk("tab_top0", top0, tab[i].t0);
      chk("tab_cnt", cnt, 32'(tab[i].cnt));
      chk("tab_rej", 32'(rej), 32'(tab[i].rej));
      chk("tab_err", 32'(err), 32'(tab[i].err));
      chk("tab_ready", 32'(ready), 32'(tab[i].rdy));
      if (tab[i].rdy) chk("tab_top1", top1, tab[i].t1);
    end
    settle();

    // Reset landing on the FILL cycle
    do_reset();
    issue(POP, 32'h0);
    issue(PUSH, 32'h1); issue(PUSH, 32'h2); issue(PUSH, 32'h3);
    issue(POP, 32'h0);
    chk("pre_rst_fill", 32'(ready), 32'd0);
    do_reset();
    issue(PUSH, 32'h1);
    chk("post_rst_top0", top0, 32'h1);
    chk("post_rst_cnt", cnt, 32'd1);

    // Full stack on the DEPTH=4 instance
    sel = 1'b1;
    do_reset();
    for (int i = 1; i <= 4; i++) issue(PUSH, 32'hA0 + 32'(i));
    issue(PUSH, 32'hAA);
    chk("full_rej", 32'(rej), 32'd1);
    chk("full_err", 32'(err), 32'd1);
    chk("full_cnt", cnt, 32'd4);
    chk("full_top0", top0, 32'hA4);
    issue(DUP, 32'h0);
    chk("full_dup_rej", 32'(rej), 32'd1);
    for (int i = 3; i >= 0; i--) begin
      issue(POP, 32'h0);
      chk("lifo_top0", top0, (i == 0) ? 32'd0 : 32'hA0 + 32'(i));
    end
    settle();

    // Random traffic against the model on both instances
    for (int k = 0; k < 2; k++) begin
      sel = (k == 1);
      do_reset();
      for (int i = 0; i < 400; i++) begin
        r_op = 3'($urandom_range(0, 7));
        if (r_op == CLEAR && $urandom_range(0, 5) != 0) r_op = PUSH;
        issue(r_op, $urandom);
        if ($urandom_range(0, 4) == 0) begin
          settle();
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
      end
      settle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
